jpeg_byte_stuffer: RTL and testbench

//   Downstream of the Huffman encoder in the JPEG pipeline (clk domain).

---
 rtl/huffman_pkg.sv | 7 +
 rtl/jpeg_bit_accum.sv | 45 ++++
 rtl/jpeg_byte_stuffer.sv | 122 ++++++++++++
 tb/tb_jpeg_byte_stuffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg: JPEG marker byte constants and the byte-stuffer state encoding.
package huffman_pkg;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI = 8'hD9;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
  typedef enum logic [2:0] {RUN, FLUSH, STUFF, EOI_FF, EOI_D9} stuffer_state_t;
endpackage

// File: rtl/jpeg_bit_accum.sv
// jpeg_bit_accum: MSB-first bit buffer with code append, byte extract and 1s padding
// of the partial top byte; bits below the fill level are always zero.
module jpeg_bit_accum #(
  parameter int CODE_W = 64,
  parameter int SIZE_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              append,
  input  logic [CODE_W-1:0] code,
  input  logic [SIZE_W-1:0] size,
  input  logic              extract,
  input  logic              pad,
  output logic [SIZE_W:0]   fill,
  output logic [7:0]        top
);
  localparam int BUF_W = CODE_W + 8;
  localparam int FILL_W = SIZE_W + 1;
  logic [BUF_W-1:0] bits_q, bits_d;
  logic [FILL_W-1:0] fill_q, fill_d, sh;
  logic [CODE_W-1:0] mask;
  assign mask = size == '0 ? '0 : {CODE_W{1'b1}} >> (SIZE_W'(CODE_W) - size);
  // Shift that lands the code's MSB just below the existing fill bits.
  assign sh = FILL_W'(BUF_W) - fill_q - FILL_W'(size);
  assign fill = fill_q;
  assign top = bits_q[BUF_W-1 -: 8];
  always_comb begin
    bits_d = append  ? bits_q | ({8'h00, code & mask} << sh)
           : pad     ? bits_q | {8'hFF >> fill_q[2:0], {CODE_W{1'b0}}}
           : extract ? bits_q << 8
           : bits_q;
    fill_d = append  ? fill_q + FILL_W'(size)
           : pad     ? FILL_W'(8)
           : extract ? fill_q - FILL_W'(8)
           : fill_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
    end
endmodule

// File: rtl/jpeg_byte_stuffer.sv
// jpeg_byte_stuffer: packs Huffman codes into a byte stream with 0xFF/0x00 stuffing and
// 1s padding at end of picture; define JPEG_EOI_MARKER_EN to append an FF D9 marker.
module jpeg_byte_stuffer #(
  parameter int CODE_W = 64,
  parameter int SIZE_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [SIZE_W-1:0] in_size,
  input  logic              in_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last
);
  import huffman_pkg::*;
`ifdef JPEG_EOI_MARKER_EN
  localparam bit EOI_EN = 1'b1;
`else
  localparam bit EOI_EN = 1'b0;
`endif
  localparam int FILL_W = SIZE_W + 1;
  stuffer_state_t state_q, state_d, ret_q, ret_d;
  logic stuff_last_q, stuff_last_d, live_q;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [7:0] out_byte_q, out_byte_d, top;
  logic [FILL_W-1:0] fill;
  logic accept, free, full, fin, extract, pad;
  assign full = |fill[FILL_W-1:3];
  assign fin = fill == FILL_W'(8);
  assign free = !out_valid_q || out_ready;
  // The next picture waits until the previous picture's last byte has left.
  assign in_ready = live_q && state_q == RUN && !full && !(out_valid_q && out_last_q);
  assign accept = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_byte = out_byte_q;
  assign out_last = out_last_q;
  jpeg_bit_accum #(.CODE_W(CODE_W), .SIZE_W(SIZE_W)) u_accum (
    .clk(clk), .rst_n(rst_n), .append(accept), .code(in_code), .size(in_size),
    .extract(extract), .pad(pad), .fill(fill), .top(top)
  );
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    stuff_last_d = stuff_last_q;
    out_valid_d = out_valid_q && !out_ready;
    out_byte_d = out_byte_q;
    out_last_d = out_last_q;
    extract = 1'b0;
    pad = 1'b0;
    if (state_q == RUN && accept && in_eop) state_d = FLUSH;
    if (free) begin
      case (state_q)
        RUN, FLUSH: begin
          if (full) begin
            extract = 1'b1;
            out_valid_d = 1'b1;
            out_byte_d = top;
            out_last_d = state_q == FLUSH && fin && !EOI_EN && top != JPEG_MARKER_PREFIX;
            if (top == JPEG_MARKER_PREFIX) begin
              state_d = STUFF;
              stuff_last_d = state_q == FLUSH && fin && !EOI_EN;
              ret_d = state_q == RUN ? RUN : (!fin ? FLUSH : (EOI_EN ? EOI_FF : RUN));
            end else if (state_q == FLUSH && fin) state_d = EOI_EN ? EOI_FF : RUN;
          end else if (state_q == FLUSH) begin
`ifdef JPEG_EOI_MARKER_EN
            if (fill == '0) state_d = EOI_FF;
            else pad = 1'b1;
`else
            pad = 1'b1;
`endif
          end
        end
        STUFF: begin
          out_valid_d = 1'b1;
          out_byte_d = JPEG_STUFF;
          out_last_d = stuff_last_q;
          state_d = ret_q;
        end
`ifdef JPEG_EOI_MARKER_EN
        EOI_FF: begin
          out_valid_d = 1'b1;
          out_byte_d = JPEG_MARKER_PREFIX;
          out_last_d = 1'b0;
          state_d = EOI_D9;
        end
        EOI_D9: begin
          out_valid_d = 1'b1;
          out_byte_d = JPEG_EOI;
          out_last_d = 1'b1;
          state_d = RUN;
        end
`endif
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      ret_q <= RUN;
      stuff_last_q <= 1'b0;
      live_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q <= 8'h00;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      stuff_last_q <= stuff_last_d;
      live_q <= 1'b1;
      out_valid_q <= out_valid_d;
      out_byte_q <= out_byte_d;
      out_last_q <= out_last_d;
    end
`ifdef __SIM__
  always @(posedge clk) if (rst_n && accept) assert (in_size <= SIZE_W'(CODE_W));
`endif
endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// tb_jpeg_byte_stuffer: scoreboard bench; a bit-level reference model queues expected
// {last,byte} pairs as beats are accepted and a negedge monitor pops them on each handshake.
module tb_jpeg_byte_stuffer;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_eop = 1'b0, out_ready = 1'b1;
  logic [63:0] in_code = '0;
  logic [6:0] in_size = '0;
  logic in_ready, out_valid, out_last;
  logic [7:0] out_byte;
  int compared = 0, mismatched = 0, nbytes = 0;
  logic [8:0] exp_q[$];
  bit bits_q[$];
  bit rnd_done;

  jpeg_byte_stuffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_size(in_size), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic void emit(input logic [7:0] b, input logic fin);
`ifdef JPEG_EOI_MARKER_EN
    exp_q.push_back({1'b0, b});
    if (b == 8'hFF) exp_q.push_back(9'h000);
    if (fin) begin
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h1D9);
    end
`else
    if (b == 8'hFF) begin
      exp_q.push_back(9'h0FF);
      exp_q.push_back({fin, 8'h00});
    end else exp_q.push_back({fin, b});
`endif
  endfunction

  function automatic logic [7:0] pop8();
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], bits_q.pop_front()};
    return b;
  endfunction

  function automatic void model_add(input logic [63:0] c, input logic [6:0] s, input logic e);
    for (int i = int'(s) - 1; i >= 0; i--) bits_q.push_back(c[i]);
    while (bits_q.size() > (e ? 8 : 7)) emit(pop8(), 1'b0);
    if (e) begin
`ifdef JPEG_EOI_MARKER_EN
      if (bits_q.size() == 0) begin
        exp_q.push_back(9'h0FF);
        exp_q.push_back(9'h1D9);
        return;
      end
`endif
      while (bits_q.size() < 8) bits_q.push_back(1'b1);
      emit(pop8(), 1'b1);
    end
  endfunction

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && out_valid && out_ready) begin
      compared++;
      nbytes++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_byte: got byte %02h last %0b, expected no byte", out_byte, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_byte} !== e) begin
          mismatched++;
          $display("FAIL stream_byte: got byte %02h last %0b, expected byte %02h last %0b",
                   out_byte, out_last, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic send(input logic [63:0] c, input logic [6:0] s, input logic e);
    int n = 0;
    in_valid = 1'b1;
    in_code = c;
    in_size = s;
    in_eop = e;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready %0b, expected 1 within 300 cycles", in_ready);
    end else model_add(c, s, e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d bytes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    compared++;
    if ({out_valid, out_byte, out_last, in_ready} !== 11'h000) begin
      mismatched++;
      $display("FAIL reset_outputs: valid %0b byte %02h last %0b in_ready %0b, expected 0 00 0 0",
               out_valid, out_byte, out_last, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: in_ready %0b, expected 1", in_ready);
    end
  endtask

  task automatic test_pack();
    send(64'h5, 7'd3, 1'b0);
    send(64'h1F, 7'd5, 1'b0);
    drain("pack");
  endtask

  task automatic test_stuff();
    send(64'hFF, 7'd8, 1'b0);
    send(64'h01, 7'd8, 1'b0);
    drain("stuff");
  endtask

  task automatic test_eop();
    send(64'h2, 7'd2, 1'b1);
    drain("eop");
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL eop_ready_return: in_ready %0b, expected 1", in_ready);
    end
    send(64'h0, 7'd0, 1'b1);
    drain("eop_empty");
  endtask

  task automatic test_wide();
    send({64{1'b1}}, 7'd64, 1'b0);
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL wide_ready_low: in_ready %0b, expected 0", in_ready);
    end
    drain("wide");
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL wide_ready_high: in_ready %0b, expected 1", in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    send(64'hFF, 7'd8, 1'b0);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (out_valid !== 1'b1 || out_byte !== 8'hFF) begin
      mismatched++;
      $display("FAIL hold_start: valid %0b byte %02h, expected 1 FF", out_valid, out_byte);
    end
    repeat (5) begin
      @(negedge clk);
      compared++;
      if ({out_valid, out_last, out_byte} !== 10'h2FF) begin
        mismatched++;
        $display("FAIL hold_stable: valid %0b last %0b byte %02h, expected 1 0 FF",
                 out_valid, out_last, out_byte);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(64'h01, 7'd8, 1'b0);
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    int nb;
    out_ready = 1'b1;
    send({64{1'b1}}, 7'd64, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_valid: out_valid %0b, expected 1 before reset", out_valid);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_drop: valid %0b in_ready %0b, expected 0 0", out_valid, in_ready);
    end
    exp_q.delete();
    bits_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nb = nbytes;
    send(64'h5, 7'd3, 1'b0);
    send(64'h1F, 7'd5, 1'b0);
    drain("reset_mid");
    compared++;
    if (nbytes - nb != 1) begin
      mismatched++;
      $display("FAIL mid_byte_count: got %0d bytes, expected 1", nbytes - nb);
    end
  endtask

  task automatic test_back_to_back();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send({$urandom, $urandom}, 7'($urandom_range(0, 20)), i == 39);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
        out_ready = 1'b1;
      end
    join
    drain("back_to_back");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_pack();
    test_stuff();
    test_eop();
    test_wide();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
